// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by seq_alu, seq_mul and the control unit's decoder.
//   - ALU_* : 3-bit operation codes carried on the ALU select bus.
//   - alu_state_e : handshake FSM state encoding of seq_alu.
//   - ovf_flag : signed-overflow rule shared by add and sub.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Add overflows when both operands share a sign that the result lost;
  // sub overflows when the operand signs differ and the result left A's sign.
  // In both cases the result sign differs from A's sign.
  function automatic logic ovf_flag(input logic is_sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic same_sign;
    same_sign = (a_msb == b_msb);
    return (is_sub ? !same_sign : same_sign) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start_i         : load operands and begin (honoured only when not busy)
//   a_i, b_i        : multiplicand, multiplier (WIDTH bits)
//   busy_o          : iteration in progress
//   done_o          : the final iteration happens on the coming clock edge
//   product_o       : 2*WIDTH-bit product, valid while done_o is high
// The accumulator holds {partial sum, remaining multiplier bits}; each
// iteration conditionally adds the multiplicand to the upper half and shifts
// the whole register right by one.
module seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       sum;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (start_i && !busy_q) begin
      acc_d   = {{WIDTH{1'b0}}, b_i};
      mcand_d = a_i;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      // carry out of the add becomes the new MSB after the shift
      acc_d = {sum, acc_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  // Next-state view so the caller can register the product on the same edge
  // as the final iteration, without an extra cycle of latency.
  assign product_o = acc_d;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered 32-bit-style ALU with multi-cycle multiply.
// Optional feature macro: SEQ_ALU_MUL_EN (defined -> seq_mul built and op 011
// multiplies over WIDTH cycles; undefined -> op 011 is a single-cycle op
// returning 0 with zero=1).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   inp_A, inp_B        : operands (WIDTH bits), select : op code
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out, out_hi         : result / product low half, product high half
//   zero, ovf           : out==0, signed overflow for add/sub
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             ovf
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] out_q, out_hi_q;
  logic             zero_q, ovf_q;

  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic [WIDTH-1:0] sum, diff;
  logic             start_mul;

  always_comb begin
    sum   = inp_A + inp_B;
    diff  = inp_A - inp_B;
    res_d = '0;
    ovf_d = 1'b0;
    case (select)
      ALU_ADD: begin
        res_d = sum;
        ovf_d = ovf_flag(1'b0, inp_A[WIDTH-1], inp_B[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_XOR: res_d = inp_A ^ inp_B;
      ALU_SUB: begin
        res_d = diff;
        ovf_d = ovf_flag(1'b1, inp_A[WIDTH-1], inp_B[WIDTH-1], diff[WIDTH-1]);
      end
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(inp_A) < $signed(inp_B))};
      ALU_NOR: res_d = ~(inp_A | inp_B);
      ALU_AND: res_d = inp_A & inp_B;
      ALU_OR:  res_d = inp_A | inp_B;
      default: res_d = '0;  // ALU_MUL without a multiplier yields 0
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic                 mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  assign start_mul = (select == ALU_MUL);

  seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   ((state_q == ST_IDLE) && in_valid && start_mul && !mul_busy),
    .a_i       (inp_A),
    .b_i       (inp_B),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`else
  assign start_mul = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (start_mul) begin
              state_q <= ST_MUL;
            end else begin
              out_q    <= res_d;
              out_hi_q <= '0;
              zero_q   <= (res_d == '0);
              ovf_q    <= ovf_d;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
`ifdef SEQ_ALU_MUL_EN
          // mul_done marks the edge of the last iteration; mul_prod is the
          // value the accumulator takes on that edge.
          if (mul_done) begin
            out_q    <= mul_prod[WIDTH-1:0];
            out_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            zero_q   <= (mul_prod[WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
            state_q  <= ST_DONE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu (WIDTH=32).
// Stimulus pushes the reference-model result on every accepted op; a monitor
// compares every cycle the DUT presents out_valid and pops on handoff.
module tb_seq_alu;

  localparam int unsigned W = 32;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b110;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, zero, ovf;
  logic [W-1:0] inp_A, inp_B, out, out_hi;
  logic [2:0] select;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp_A     (inp_A),
    .inp_B     (inp_B),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.lo = '0;
    e.hi = '0;
    e.v  = 1'b0;
    case (op)
      3'b000: begin s = sa + sb; e.lo = a + b; e.v = (s != longint'($signed(e.lo))); end
      3'b001: e.lo = a ^ b;
      3'b010: begin s = sa - sb; e.lo = a - b; e.v = (s != longint'($signed(e.lo))); end
      3'b011: if (MUL_EN) begin
                p = {32'h0, a} * {32'h0, b};
                e.lo = p[31:0];
                e.hi = p[63:32];
              end
      3'b100: e.lo = (sa < sb) ? 32'd1 : 32'd0;
      3'b101: e.lo = ~(a | b);
      3'b110: e.lo = a & b;
      default: e.lo = a | b;
    endcase
    e.z = (e.lo == 32'h0);
    return e;
  endfunction

  // Monitor: while a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out=%0h with no pending op at %0t", out, $time);
      end else begin
        mon_e = sbq[0];
        chk("out", 64'(out), 64'(mon_e.lo));
        chk("out_hi", 64'(out_hi), 64'(mon_e.hi));
        chk("zero", 64'(zero), 64'(mon_e.z));
        chk("ovf", 64'(ovf), 64'(mon_e.v));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("issue_timeout_in_ready", 64'(in_ready), 64'd1);
    inp_A = a; inp_B = b; select = op; in_valid = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(model(a, b, op));
    in_valid = 1'b0;
    inp_A = $urandom; inp_B = $urandom; select = 3'($urandom);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int hold, input bit poke, input bit pre);
    int lat = 1;
    int exp_lat;
    bit ir_bad = 1'b0;
    exp_lat = (MUL_EN && op == OP_MUL) ? int'(W) + 1 : 1;
    out_ready = pre;
    issue(a, b, op);
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ir_bad = 1'b1;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("in_ready_while_busy", 64'(ir_bad), 64'd0);
    repeat (hold) begin
      if (poke) begin
        in_valid = 1'b1; inp_A = $urandom; inp_B = $urandom; select = 3'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_handoff", 64'(in_ready), 64'd1);
    chk("out_valid_after_handoff", 64'(out_valid), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out"}, 64'(out), 64'd0);
    chk({tag, "_out_hi"}, 64'(out_hi), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd1);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] edges [6];
    logic [31:0] ra, rb;
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'h0000_0001; edges[5] = 32'h0000_0002;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inp_A = '0; inp_B = '0; select = '0;
    #1;
    reset_checks("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // directed cases
    do_op(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 0, 1'b0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0005, OP_SUB, 0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, OP_SUB, 0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 0, 1'b0, 1'b0);
    do_op(32'h0000_0001, 32'hFFFF_FFFF, OP_SLT, 0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0002, OP_MUL, 0, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h9ABC_DEF0, OP_XOR, 5, 1'b1, 1'b0);
    do_op(32'h0000_0003, 32'h0000_0004, OP_ADD, 0, 1'b0, 1'b0);
    do_op(32'h0000_F0F0, 32'h0000_0FF0, OP_AND, 0, 1'b0, 1'b1);

    // reset while a multiply is in flight
    out_ready = 1'b0;
    issue(32'hDEAD_BEEF, 32'h0000_0007, OP_MUL);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    sbq.delete();
    #1;
    reset_checks("midmul_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    do_op(32'h0000_0003, 32'h0000_0004, OP_ADD, 0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int hold;
      bit pre;
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      hold = $urandom_range(0, 3);
      pre = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op(ra, rb, 3'($urandom_range(0, 7)), hold, 1'($urandom_range(0, 1)), pre);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
